opl3_output_mixer: RTL and testbench
====================================

Name: opl3_output_mixer

Overview:
Parametrised successor to the fixed 4-channel digital L/R sum at the OPL3 top level.
- Takes NUM_CH signed channel samples and applies a per-channel gain and L/R routing.
- Accumulates the channels one per clock after each sample_clk_en, then shifts and saturates to the DAC width.
- Sits between `channels` and the DAC/I2S path, in the opl3 clk domain.

Parameters:
NUM_CH, 4, number of input channels (2..16)
SAMPLE_WIDTH, 16, signed width of each channel input
GAIN_WIDTH, 4, unsigned per-channel gain width
GAIN_FRAC, 3, fractional bits of gain (gain 8 = unity)
DAC_OUTPUT_WIDTH, 24, signed output width
DAC_LEFT_SHIFT, 2, left shift applied after gain normalisation

Ports:
clk  in  1  opl3 clock
reset  in  1  synchronous, active-high reset
sample_clk_en  in  1  one-cycle strobe; snapshot inputs and start a mix
channel_in  in  NUM_CH*SAMPLE_WIDTH  flattened signed samples, ch0 at LSBs
cfg_wr  in  1  config write strobe
cfg_ch  in  $clog2(NUM_CH)  channel index for write
cfg_gain  in  GAIN_WIDTH  gain for cfg_ch
cfg_route  in  2  bit0 = to left, bit1 = to right
sample_l  out  DAC_OUTPUT_WIDTH  signed left output
sample_r  out  DAC_OUTPUT_WIDTH  signed right output
sample_valid  out  1  one-cycle pulse when sample_l/r update
busy  out  1  mix in progress
overrun  out  1  sticky: sample_clk_en arrived while busy

Behaviour:
- One clock (clk). Reset is synchronous and active-high on `reset`.
- Reset values:
  - sample_l = 0, sample_r = 0, sample_valid = 0, busy = 0, overrun = 0.
  - State = IDLE, accumulators = 0.
  - All gains = 1<<GAIN_FRAC.
  - Route: even channels = 2'b01 (left), odd channels = 2'b10 (right). This reproduces the legacy a+c left, b+d right mix.
- Config registers:
  - On cfg_wr, gain[cfg_ch] and route[cfg_ch] update next cycle.
  - If cfg_ch >= NUM_CH, the write is ignored.
  - Any cfg_wr clears overrun. Simultaneous overrun set and cfg_wr: set wins.
- FSM states: IDLE, ACCUM, OUTPUT.
  - IDLE --sample_clk_en--> ACCUM.
    - Same cycle: snapshot channel_in, all gains and all routes into shadow registers.
    - Clear both accumulators; set idx = 0; busy = 1.
  - ACCUM: one channel per cycle, idx = 0..NUM_CH-1.
    - prod = sample[idx] * $signed({1'b0, gain[idx]}).
    - Add prod to acc_l if route[idx][0]; add to acc_r if route[idx][1]. Route 00 = muted, 11 = both.
    - After idx = NUM_CH-1, go to OUTPUT.
  - OUTPUT:
    - Per side: v = (acc >>> GAIN_FRAC) <<< DAC_LEFT_SHIFT. Arithmetic shift, truncates toward -inf.
    - Saturate v to [-2^(DAC_OUTPUT_WIDTH-1), 2^(DAC_OUTPUT_WIDTH-1)-1] and register to sample_l/r.
    - sample_valid = 1 for this one cycle; then go to IDLE with busy = 0.
- Latency: sample_clk_en at cycle T gives sample_valid at T+NUM_CH+1. Outputs hold between pulses.
- Accumulator width: SAMPLE_WIDTH+GAIN_WIDTH+1+$clog2(NUM_CH). It must never wrap internally.
- Config writes during a mix do not affect that mix; they take effect at the next snapshot.
- sample_clk_en while busy (ACCUM or OUTPUT):
  - The strobe is dropped and overrun is set.
  - The current mix completes unaffected.
- sample_clk_en in the same cycle that OUTPUT returns to IDLE also counts as busy and is dropped. CLK_DIV_COUNT must exceed NUM_CH+1.
- Reset mid-mix aborts immediately to IDLE with reset values. No sample_valid pulse is produced.

Test Plan:
- Defaults; ch0=1000, ch1=-500, ch2=2000, ch3=0; pulse sample_clk_en -> after 5 cycles sample_valid=1 for exactly 1 cycle, sample_l=12000, sample_r=-2000; busy high for those 5 cycles.
- Write ch1 gain=4 and route=2'b11; ch2 route=2'b00; same inputs -> sample_l=3000>>3<<2: acc_l = 8000 - 2000 = 6000, so sample_l=3000; sample_r=-1000.
- Saturation with DAC_OUTPUT_WIDTH=18: all gains 15, all routes 2'b01, all inputs 32767 -> sample_l=131071, sample_r=0. All inputs -32768 -> sample_l=-131072.
- Negative truncation: ch0=-1 with gain 1, others 0 -> acc=-1, >>>3 gives -1, <<2 gives sample_l=-4.
- Overrun: second sample_clk_en 2 cycles after the first -> one sample_valid only, overrun=1 sticky; then a cfg_wr with cfg_ch=7 (ignored index) clears overrun while gains are unchanged.
- Reset asserted during ACCUM (idx=2) -> next cycle busy=0, sample_l/r=0, no sample_valid; the next sample_clk_en mixes normally with default gains and routes.

Source files
------------

// File: rtl/opl3_output_mixer.sv
// Purpose : per-channel gain + L/R routing mixer summing NUM_CH signed channel
//           samples into one stereo DAC sample, saturated to DAC_OUTPUT_WIDTH.
// Latency : sample_clk_en at cycle T -> sample_valid pulse at T+NUM_CH+1.
// Backpr. : none; a strobe that lands while a mix is running is dropped and
//           latches the sticky overrun flag until the next cfg_wr.
//
// Ports:
//   clk, reset           opl3 clock, synchronous active-high reset
//   sample_clk_en        strobe: snapshot inputs/config and start a mix
//   channel_in           flattened signed samples, ch0 in the LSBs
//   cfg_wr/ch/gain/route per-channel gain and routing write (route bit0=L, bit1=R)
//   sample_l/r           saturated signed outputs, held between pulses
//   sample_valid         one-cycle pulse when sample_l/r update
//   busy                 mix in progress (ACCUM or OUTPUT)
//   overrun              sticky: strobe arrived while busy; cleared by cfg_wr
module opl3_output_mixer #(
  parameter int NUM_CH           = 4,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int GAIN_WIDTH       = 4,
  parameter int GAIN_FRAC        = 3,
  parameter int DAC_OUTPUT_WIDTH = 24,
  parameter int DAC_LEFT_SHIFT   = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               sample_clk_en,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0]     channel_in,
  input  logic                               cfg_wr,
  input  logic [$clog2(NUM_CH)-1:0]          cfg_ch,
  input  logic [GAIN_WIDTH-1:0]              cfg_gain,
  input  logic [1:0]                         cfg_route,
  output logic signed [DAC_OUTPUT_WIDTH-1:0] sample_l,
  output logic signed [DAC_OUTPUT_WIDTH-1:0] sample_r,
  output logic                               sample_valid,
  output logic                               busy,
  output logic                               overrun
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int PROD_W = SAMPLE_WIDTH + GAIN_WIDTH + 1;
  // Headroom of CH_W bits above one product: the sum of NUM_CH products cannot wrap.
  localparam int ACC_W  = PROD_W + CH_W;
  localparam int SHL_W  = ACC_W + DAC_LEFT_SHIFT;
  // Working width for shift/saturate: wide enough for the shifted sum and the DAC limits.
  localparam int EXT_W  = ((SHL_W > DAC_OUTPUT_WIDTH) ? SHL_W : DAC_OUTPUT_WIDTH) + 1;

  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-DAC_OUTPUT_WIDTH+1){1'b0}}, {(DAC_OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_e;

  state_e                              state_q, state_d;
  logic [CH_W-1:0]                     idx_q, idx_d;
  logic signed [ACC_W-1:0]             acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [GAIN_WIDTH-1:0]               gain_q [NUM_CH];
  logic [GAIN_WIDTH-1:0]               gain_d [NUM_CH];
  logic [1:0]                          route_q [NUM_CH];
  logic [1:0]                          route_d [NUM_CH];
  logic [SAMPLE_WIDTH-1:0]             sh_samp_q [NUM_CH];
  logic [SAMPLE_WIDTH-1:0]             sh_samp_d [NUM_CH];
  logic [GAIN_WIDTH-1:0]               sh_gain_q [NUM_CH];
  logic [GAIN_WIDTH-1:0]               sh_gain_d [NUM_CH];
  logic [1:0]                          sh_route_q [NUM_CH];
  logic [1:0]                          sh_route_d [NUM_CH];
  logic signed [DAC_OUTPUT_WIDTH-1:0]  sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic                                valid_q, valid_d;
  logic                                busy_q, busy_d;
  logic                                overrun_q, overrun_d;

  // Datapath for the channel selected by idx_q, and the final shift/saturate.
  logic [SAMPLE_WIDTH-1:0]  cur_samp;
  logic [GAIN_WIDTH-1:0]    cur_gain;
  logic [1:0]               cur_route;
  logic signed [PROD_W-1:0] samp_x, gain_x, prod;
  logic signed [ACC_W-1:0]  prod_x;
  logic signed [EXT_W-1:0]  acc_l_x, acc_r_x, shl_l, shl_r;
  logic signed [DAC_OUTPUT_WIDTH-1:0] sat_l, sat_r;

  function automatic logic signed [DAC_OUTPUT_WIDTH-1:0] saturate(
    input logic signed [EXT_W-1:0] v
  );
    if (v > SAT_MAX)      return SAT_MAX[DAC_OUTPUT_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DAC_OUTPUT_WIDTH-1:0];
    else                  return v[DAC_OUTPUT_WIDTH-1:0];
  endfunction

  always_comb begin
    cur_samp  = sh_samp_q[idx_q];
    cur_gain  = sh_gain_q[idx_q];
    cur_route = sh_route_q[idx_q];
    // Gain is unsigned: zero-extend it so the signed multiply treats 15 as +15.
    samp_x    = {{(GAIN_WIDTH+1){cur_samp[SAMPLE_WIDTH-1]}}, cur_samp};
    gain_x    = {{SAMPLE_WIDTH{1'b0}}, 1'b0, cur_gain};
    prod      = samp_x * gain_x;
    prod_x    = {{CH_W{prod[PROD_W-1]}}, prod};
    acc_l_x   = {{(EXT_W-ACC_W){acc_l_q[ACC_W-1]}}, acc_l_q};
    acc_r_x   = {{(EXT_W-ACC_W){acc_r_q[ACC_W-1]}}, acc_r_q};
    // Arithmetic right shift floors toward -inf (e.g. -1 stays -1).
    shl_l     = (acc_l_x >>> GAIN_FRAC) <<< DAC_LEFT_SHIFT;
    shl_r     = (acc_r_x >>> GAIN_FRAC) <<< DAC_LEFT_SHIFT;
    sat_l     = saturate(shl_l);
    sat_r     = saturate(shl_r);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_l_d    = acc_l_q;
    acc_r_d    = acc_r_q;
    gain_d     = gain_q;
    route_d    = route_q;
    sh_samp_d  = sh_samp_q;
    sh_gain_d  = sh_gain_q;
    sh_route_d = sh_route_q;
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    overrun_d  = overrun_q;

    // Decoded compare: an index with no matching channel simply hits nothing.
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_wr && (cfg_ch == CH_W'(i))) begin
        gain_d[i]  = cfg_gain;
        route_d[i] = cfg_route;
      end
    end

    // Set takes priority over the cfg_wr clear.
    if (cfg_wr) overrun_d = 1'b0;
    if (sample_clk_en && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (sample_clk_en) begin
          // Snapshot uses the pre-write config; a same-cycle cfg_wr lands next mix.
          for (int i = 0; i < NUM_CH; i++) begin
            sh_samp_d[i] = channel_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
          end
          sh_gain_d  = gain_q;
          sh_route_d = route_q;
          acc_l_d    = '0;
          acc_r_d    = '0;
          idx_d      = '0;
          busy_d     = 1'b1;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (cur_route[0]) acc_l_d = acc_l_q + prod_x;
        if (cur_route[1]) acc_r_d = acc_r_q + prod_x;
        if (idx_q == LAST_IDX) state_d = OUTPUT;
        else                   idx_d   = idx_q + CH_W'(1);
      end
      OUTPUT: begin
        sample_l_d = sat_l;
        sample_r_d = sat_r;
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        gain_q[i]     <= GAIN_WIDTH'(1 << GAIN_FRAC);
        // Even channels left, odd right: the legacy a+c / b+d stereo split.
        route_q[i]    <= (i % 2 == 1) ? 2'b10 : 2'b01;
        sh_samp_q[i]  <= '0;
        sh_gain_q[i]  <= '0;
        sh_route_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      gain_q     <= gain_d;
      route_q    <= route_d;
      sh_samp_q  <= sh_samp_d;
      sh_gain_q  <= sh_gain_d;
      sh_route_q <= sh_route_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_opl3_output_mixer.sv
// Directed bench for opl3_output_mixer: instance A uses default parameters,
// instance B uses NUM_CH=5 and an 18-bit DAC (saturation, out-of-range cfg_ch).
module tb_opl3_output_mixer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Instance A: 4 channels, 24-bit output
  logic        reset_a, strobe_a, cfg_wr_a;
  logic [63:0] ch_in_a;
  logic [1:0]  cfg_ch_a;
  logic [3:0]  cfg_gain_a;
  logic [1:0]  cfg_route_a;
  logic signed [23:0] l_a, r_a;
  logic        valid_a, busy_a, ovr_a;

  // Instance B: 5 channels, 18-bit output
  logic        reset_b, strobe_b, cfg_wr_b;
  logic [79:0] ch_in_b;
  logic [2:0]  cfg_ch_b;
  logic [3:0]  cfg_gain_b;
  logic [1:0]  cfg_route_b;
  logic signed [17:0] l_b, r_b;
  logic        valid_b, busy_b, ovr_b;

  opl3_output_mixer dut_a (
    .clk(clk), .reset(reset_a), .sample_clk_en(strobe_a), .channel_in(ch_in_a),
    .cfg_wr(cfg_wr_a), .cfg_ch(cfg_ch_a), .cfg_gain(cfg_gain_a), .cfg_route(cfg_route_a),
    .sample_l(l_a), .sample_r(r_a), .sample_valid(valid_a), .busy(busy_a), .overrun(ovr_a)
  );

  opl3_output_mixer #(.NUM_CH(5), .DAC_OUTPUT_WIDTH(18)) dut_b (
    .clk(clk), .reset(reset_b), .sample_clk_en(strobe_b), .channel_in(ch_in_b),
    .cfg_wr(cfg_wr_b), .cfg_ch(cfg_ch_b), .cfg_gain(cfg_gain_b), .cfg_route(cfg_route_b),
    .sample_l(l_b), .sample_r(r_b), .sample_valid(valid_b), .busy(busy_b), .overrun(ovr_b)
  );

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int c0, input int c1, input int c2, input int c3);
    ch_in_a = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endtask

  task automatic set_b(input int c0, input int c1, input int c2, input int c3, input int c4);
    ch_in_b = {16'(c4), 16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endtask

  task automatic cfg_a(input int ch, input int gain, input int route);
    cfg_wr_a = 1'b1; cfg_ch_a = 2'(ch); cfg_gain_a = 4'(gain); cfg_route_a = 2'(route);
    tick();
    cfg_wr_a = 1'b0;
  endtask

  task automatic cfg_b(input int ch, input int gain, input int route);
    cfg_wr_b = 1'b1; cfg_ch_b = 3'(ch); cfg_gain_b = 4'(gain); cfg_route_b = 2'(route);
    tick();
    cfg_wr_b = 1'b0;
  endtask

  task automatic pulse_a();
    strobe_a = 1'b1;
    tick();
    strobe_a = 1'b0;
  endtask

  task automatic pulse_b();
    strobe_b = 1'b1;
    tick();
    strobe_b = 1'b0;
  endtask

  // Cycles from the strobe edge to the valid pulse, -1 if none within budget.
  task automatic wait_valid_a(output int lat);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (valid_a === 1'b1) begin lat = c; break; end
    end
  endtask

  task automatic wait_valid_b(output int lat);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (valid_b === 1'b1) begin lat = c; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1;
    tick(); tick();
    reset_a = 1'b0; reset_b = 1'b0;
    tests_run++; if (l_a !== 24'sd0) begin tests_failed++; $display("FAIL reset_l: got %0d want 0", l_a); end
    tests_run++; if (r_a !== 24'sd0) begin tests_failed++; $display("FAIL reset_r: got %0d want 0", r_a); end
    tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    tests_run++; if (ovr_a !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", ovr_a); end
    tests_run++; if (busy_b !== 1'b0 || ovr_b !== 1'b0) begin tests_failed++; $display("FAIL reset_b: got busy=%b ovr=%b want 0/0", busy_b, ovr_b); end
  endtask

  task automatic test_basic();
    int bad;
    bad = 0;
    set_a(1000, -500, 2000, 0);
    pulse_a();
    for (int c = 0; c < 5; c++) begin
      if (busy_a !== 1'b1 || valid_a !== 1'b0) bad++;
      tick();
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL basic_busy_window: got %0d bad cycles want 0", bad); end
    tests_run++; if (valid_a !== 1'b1) begin tests_failed++; $display("FAIL basic_valid_latency: got %b want 1", valid_a); end
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_done: got %b want 0", busy_a); end
    tests_run++; if (l_a !== 24'sd12000) begin tests_failed++; $display("FAIL basic_l: got %0d want 12000", l_a); end
    tests_run++; if (r_a !== -24'sd2000) begin tests_failed++; $display("FAIL basic_r: got %0d want -2000", r_a); end
    tick();
    tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_width: got %b want 0", valid_a); end
    tests_run++; if (l_a !== 24'sd12000) begin tests_failed++; $display("FAIL basic_hold: got %0d want 12000", l_a); end
  endtask

  task automatic test_cfg_route();
    int lat;
    cfg_a(1, 4, 3);
    cfg_a(2, 8, 0);
    pulse_a();
    wait_valid_a(lat);
    tests_run++; if (lat != 5) begin tests_failed++; $display("FAIL route_latency: got %0d want 5", lat); end
    tests_run++; if (l_a !== 24'sd3000) begin tests_failed++; $display("FAIL route_l: got %0d want 3000", l_a); end
    tests_run++; if (r_a !== -24'sd1000) begin tests_failed++; $display("FAIL route_r: got %0d want -1000", r_a); end
  endtask

  task automatic test_cfg_during_mix();
    int lat;
    pulse_a();
    cfg_a(0, 0, 1);
    wait_valid_a(lat);
    tests_run++; if (lat < 0 || l_a !== 24'sd3000) begin tests_failed++; $display("FAIL midcfg_current: got %0d want 3000", l_a); end
    pulse_a();
    wait_valid_a(lat);
    tests_run++; if (lat != 5 || l_a !== -24'sd1000) begin tests_failed++; $display("FAIL midcfg_next_l: got %0d want -1000", l_a); end
    tests_run++; if (r_a !== -24'sd1000) begin tests_failed++; $display("FAIL midcfg_next_r: got %0d want -1000", r_a); end
  endtask

  task automatic test_mid_reset();
    int nv, lat;
    nv = 0;
    pulse_a();
    tick(); tick();
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    tests_run++; if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy: got %b want 0", busy_a); end
    tests_run++; if (l_a !== 24'sd0 || r_a !== 24'sd0) begin tests_failed++; $display("FAIL rst_mid_out: got %0d/%0d want 0/0", l_a, r_a); end
    for (int c = 0; c < 10; c++) begin
      if (valid_a === 1'b1) nv++;
      tick();
    end
    tests_run++; if (nv != 0) begin tests_failed++; $display("FAIL rst_mid_no_valid: got %0d pulses want 0", nv); end
    set_a(1000, -500, 2000, 0);
    pulse_a();
    wait_valid_a(lat);
    tests_run++; if (lat != 5 || l_a !== 24'sd12000) begin tests_failed++; $display("FAIL rst_mid_remix_l: got %0d want 12000", l_a); end
    tests_run++; if (r_a !== -24'sd2000) begin tests_failed++; $display("FAIL rst_mid_remix_r: got %0d want -2000", r_a); end
  endtask

  task automatic test_neg_trunc();
    int lat;
    cfg_a(0, 1, 1);
    set_a(-1, 0, 0, 0);
    pulse_a();
    wait_valid_a(lat);
    tests_run++; if (lat != 5 || l_a !== -24'sd4) begin tests_failed++; $display("FAIL neg_trunc_l: got %0d want -4", l_a); end
    tests_run++; if (r_a !== 24'sd0) begin tests_failed++; $display("FAIL neg_trunc_r: got %0d want 0", r_a); end
  endtask

  task automatic test_overrun();
    int nv, lat;
    nv = 0;
    set_b(100, 200, 300, 400, 500);
    pulse_b();
    tick();
    strobe_b = 1'b1;
    tick();
    strobe_b = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (valid_b === 1'b1) nv++;
      tick();
    end
    tests_run++; if (nv != 1) begin tests_failed++; $display("FAIL ovr_one_valid: got %0d pulses want 1", nv); end
    tests_run++; if (l_b !== 18'sd3600 || r_b !== 18'sd2400) begin tests_failed++; $display("FAIL ovr_mix: got %0d/%0d want 3600/2400", l_b, r_b); end
    tests_run++; if (ovr_b !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky: got %b want 1", ovr_b); end
    cfg_b(7, 0, 0);
    tests_run++; if (ovr_b !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %b want 0", ovr_b); end
    pulse_b();
    wait_valid_b(lat);
    tests_run++; if (lat != 6) begin tests_failed++; $display("FAIL ovr_b_latency: got %0d want 6", lat); end
    tests_run++; if (l_b !== 18'sd3600 || r_b !== 18'sd2400) begin tests_failed++; $display("FAIL ovr_gains_kept: got %0d/%0d want 3600/2400", l_b, r_b); end
  endtask

  task automatic test_back_to_back();
    int nv;
    nv = 0;
    pulse_b();
    for (int c = 0; c < 5; c++) tick();
    // This strobe is sampled on the edge where OUTPUT returns to IDLE.
    strobe_b = 1'b1;
    tick();
    strobe_b = 1'b0;
    tests_run++; if (valid_b !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_valid: got %b want 1", valid_b); end
    tests_run++; if (ovr_b !== 1'b1) begin tests_failed++; $display("FAIL b2b_overrun: got %b want 1", ovr_b); end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (valid_b === 1'b1) nv++;
    end
    tests_run++; if (nv != 0) begin tests_failed++; $display("FAIL b2b_dropped: got %0d pulses want 0", nv); end
    cfg_b(7, 0, 0);
  endtask

  task automatic test_saturation();
    int lat;
    for (int i = 0; i < 5; i++) cfg_b(i, 15, 1);
    set_b(32767, 32767, 32767, 32767, 32767);
    pulse_b();
    wait_valid_b(lat);
    tests_run++; if (lat != 6 || l_b !== 18'sd131071) begin tests_failed++; $display("FAIL sat_pos_l: got %0d want 131071", l_b); end
    tests_run++; if (r_b !== 18'sd0) begin tests_failed++; $display("FAIL sat_pos_r: got %0d want 0", r_b); end
    set_b(-32768, -32768, -32768, -32768, -32768);
    pulse_b();
    wait_valid_b(lat);
    tests_run++; if (lat != 6 || l_b !== -18'sd131072) begin tests_failed++; $display("FAIL sat_neg_l: got %0d want -131072", l_b); end
    tests_run++; if (r_b !== 18'sd0) begin tests_failed++; $display("FAIL sat_neg_r: got %0d want 0", r_b); end
  endtask

  initial begin
    reset_a = 1'b1; strobe_a = 1'b0; cfg_wr_a = 1'b0; ch_in_a = '0;
    cfg_ch_a = '0; cfg_gain_a = '0; cfg_route_a = '0;
    reset_b = 1'b1; strobe_b = 1'b0; cfg_wr_b = 1'b0; ch_in_b = '0;
    cfg_ch_b = '0; cfg_gain_b = '0; cfg_route_b = '0;
    #1;
    test_reset();
    test_basic();
    test_cfg_route();
    test_cfg_during_mix();
    test_mid_reset();
    test_neg_trunc();
    test_overrun();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
